vote_tally_reader: RTL and testbench
====================================

# vote_tally_reader

Read-out side of the voting machine. When the machine is in result mode, this block snapshots the four candidate tallies and determines the winner with a sequential compare. It then streams a 7-byte result frame over a valid/ready byte interface to the downstream display/host link. It sits between the vote counters and the reporting output, and is the consumer of the tallies the voting logic accumulates.

## Interface
- No parameters; tallies are fixed at 8 bits and the frame is fixed at 7 bytes.
- `clock  in  1`: single clock; all logic updates on the rising edge.
- `reset  in  1`: synchronous, active-low; sampled on the rising edge of `clock`.
- `mode  in  1`: 1 = result mode. `start` is honoured only when `mode` = 1.
- `start  in  1`: level-sampled request to send a frame.
- `tally1`..`tally4  in  8 each`: live vote counts for candidates 1..4.
- `out_ready  in  1`: downstream can accept a byte this cycle.
- `out_valid  out  1`: `out_data` holds a frame byte.
- `out_data  out  8`: current frame byte.
- `busy  out  1`: frame in progress (capture, compare or send).
- `frame_done  out  1`: one-cycle pulse after the last byte transfers.
- `led  out  8`: winner byte of the most recent completed frame.

## Operation
- States: IDLE → CMP → SEND → IDLE.
- IDLE:
  - At an edge with `start`=1 and `mode`=1, capture `tally1..4` into snapshot registers, clear the compare registers, set `busy`, and go to CMP.
  - `start` is ignored when `mode`=0.
- CMP: runs exactly 4 cycles, with index i = 0..3.
  - If snap[i] > best: best := snap[i], widx := i, tie := 0.
  - Else if snap[i] == best and best != 0: tie := 1.
  - best starts at 0. An earlier index wins ties because equality never replaces widx.
- Winner byte:
  - If best == 0 (no votes at all): 0xFF.
  - Otherwise: {tie, 5'b0, widx[1:0]}.
- SEND: bytes are sent in this order:
  - 0xA5 header
  - snap1, snap2, snap3, snap4
  - winner byte
  - checksum = XOR of bytes 1..5 (header excluded)
- Byte handshake:
  - A byte transfers at an edge where `out_valid`=1 and `out_ready`=1.
  - The byte counter advances only on a transfer.
- After the 7th transfer:
  - `led` := winner byte; `frame_done`=1 for one cycle; `busy`=0; return to IDLE.
- Snapshot isolation: changes on `tally*` or `mode` after the capture edge do not affect the frame in flight.
- `start` while `busy`=1 is ignored and is not queued.
- If `start` is held high, a new frame begins at the first IDLE edge after `frame_done`, provided `mode`=1.

## Timing
- Reset values: `out_valid`=0, `out_data`=0x00, `busy`=0, `frame_done`=0, `led`=0x00, state IDLE, all snapshot and compare registers 0.
- `reset` low at any edge, including mid-frame: all outputs return to their reset values after that edge. The partial frame is abandoned with no `frame_done`.
- `start` is accepted at edge N:
  - `busy`=1 from N.
  - Compare steps happen at edges N+1..N+4.
  - `out_valid`=1 with header 0xA5 from edge N+4 onward.
  - With `out_ready` tied to 1: bytes transfer at edges N+5..N+11, and `frame_done`=1 in the cycle after edge N+11. Total: 12 cycles from accept to idle.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data` holds stable. `out_valid` never drops mid-frame.
- `out_valid` and `out_data` are registered outputs; `out_ready` has no combinational path to them.
- `frame_done` and `busy` falling occur on the same edge. `led` updates on that same edge.

## Test plan
- Reset check: hold `reset`=0 for 3 cycles → `out_valid`=0, `out_data`=0x00, `busy`=0, `frame_done`=0, `led`=0x00.
- Normal frame:
  - Stimulus: tallies 5,2,7,1; `mode`=1; 1-cycle `start`; `out_ready`=1.
  - Response: bytes A5,05,02,07,01,02,03 on consecutive edges; first `out_valid` 4 cycles after the accept edge; `frame_done` pulse; `led`=0x02.
- Tie and no-vote cases:
  - Tallies 4,9,9,0 → winner 0x81, checksum 0x85.
  - Tallies 0,0,0,0 → winner 0xFF, checksum 0xFF, `led`=0xFF.
- Backpressure:
  - Stimulus: `out_ready` pseudo-random at about 50%, tallies 5,2,7,1.
  - Response: exactly 7 transfers with the same byte sequence as the normal frame; `out_data` is constant across every stalled cycle.
- Gating and isolation:
  - `start` with `mode`=0 → `busy` stays 0.
  - Change tallies and drop `mode` during SEND → frame bytes unchanged.
  - Pulse `start` while busy → exactly one frame sent.
- Reset mid-frame:
  - Stimulus: assert `reset`=0 after the 3rd transfer.
  - Response: all outputs return to reset values on the next edge; no `frame_done`; a subsequent `start` produces a complete fresh frame.

Source files
------------

// File: rtl/vote_tally_reader.sv
// vote_tally_reader: snapshots four candidate tallies, picks the winner with a
// four-step sequential compare, and streams a 7-byte result frame over a
// valid/ready byte interface.
module vote_tally_reader (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       start,
    input  logic [7:0] tally1,
    input  logic [7:0] tally2,
    input  logic [7:0] tally3,
    input  logic [7:0] tally4,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] led
);

    localparam int unsigned TALLY_W    = 8;
    localparam int unsigned NUM_CAND   = 4;
    localparam int unsigned FRAME_LEN  = 7;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned BYTE_IDX_W = 3;

    localparam logic [TALLY_W-1:0] HEADER  = 8'hA5;
    localparam logic [TALLY_W-1:0] NO_VOTE = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_SEND
    } state_e;

    state_e                  state_q, state_d;
    logic [TALLY_W-1:0]      snap_q [NUM_CAND];
    logic [TALLY_W-1:0]      snap_d [NUM_CAND];
    logic [TALLY_W-1:0]      best_q, best_d;
    logic [IDX_W-1:0]        widx_q, widx_d;
    logic                    tie_q, tie_d;
    logic [IDX_W-1:0]        cmp_idx_q, cmp_idx_d;
    logic [BYTE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic                    out_valid_q, out_valid_d;
    logic [TALLY_W-1:0]      out_data_q, out_data_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q, frame_done_d;
    logic [TALLY_W-1:0]      led_q, led_d;

    logic [TALLY_W-1:0]      winner_c;
    logic [TALLY_W-1:0]      checksum_c;
    logic [BYTE_IDX_W-1:0]   next_idx_c;
    logic [TALLY_W-1:0]      next_byte_c;
    logic [TALLY_W-1:0]      cur_c;

    // Winner byte and checksum derived from the finished compare and snapshot
    always_comb begin
        winner_c   = (best_q == '0) ? NO_VOTE : {tie_q, 5'b0, widx_q};
        checksum_c = snap_q[0] ^ snap_q[1] ^ snap_q[2] ^ snap_q[3] ^ winner_c;
    end

    // Byte that follows the one currently presented on out_data
    always_comb begin
        next_idx_c = byte_idx_q + BYTE_IDX_W'(1);
        case (next_idx_c)
            3'd1:    next_byte_c = snap_q[0];
            3'd2:    next_byte_c = snap_q[1];
            3'd3:    next_byte_c = snap_q[2];
            3'd4:    next_byte_c = snap_q[3];
            3'd5:    next_byte_c = winner_c;
            3'd6:    next_byte_c = checksum_c;
            default: next_byte_c = HEADER;
        endcase
    end

    // Next-state and next-output logic for capture, compare and send
    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        best_d       = best_q;
        widx_d       = widx_q;
        tie_d        = tie_q;
        cmp_idx_d    = cmp_idx_q;
        byte_idx_d   = byte_idx_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        led_d        = led_q;
        cur_c        = snap_q[cmp_idx_q];

        case (state_q)
            S_IDLE: begin
                if (start && mode) begin
                    snap_d[0] = tally1;
                    snap_d[1] = tally2;
                    snap_d[2] = tally3;
                    snap_d[3] = tally4;
                    best_d    = '0;
                    widx_d    = '0;
                    tie_d     = 1'b0;
                    cmp_idx_d = '0;
                    busy_d    = 1'b1;
                    state_d   = S_CMP;
                end
            end

            S_CMP: begin
                // Strict greater-than only, so the lowest index keeps a tie
                if (cur_c > best_q) begin
                    best_d = cur_c;
                    widx_d = cmp_idx_q;
                    tie_d  = 1'b0;
                end else if ((cur_c == best_q) && (best_q != '0)) begin
                    tie_d = 1'b1;
                end
                cmp_idx_d = cmp_idx_q + IDX_W'(1);
                if (cmp_idx_q == IDX_W'(NUM_CAND - 1)) begin
                    state_d     = S_SEND;
                    out_valid_d = 1'b1;
                    out_data_d  = HEADER;
                    byte_idx_d  = '0;
                end
            end

            S_SEND: begin
                if (out_ready) begin
                    if (byte_idx_q == BYTE_IDX_W'(FRAME_LEN - 1)) begin
                        out_valid_d  = 1'b0;
                        out_data_d   = '0;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                        led_d        = winner_c;
                        state_d      = S_IDLE;
                    end else begin
                        byte_idx_d = next_idx_c;
                        out_data_d = next_byte_c;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            snap_q       <= '{default: '0};
            best_q       <= '0;
            widx_q       <= '0;
            tie_q        <= 1'b0;
            cmp_idx_q    <= '0;
            byte_idx_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            led_q        <= '0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            best_q       <= best_d;
            widx_q       <= widx_d;
            tie_q        <= tie_d;
            cmp_idx_q    <= cmp_idx_d;
            byte_idx_q   <= byte_idx_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            led_q        <= led_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign led        = led_q;

endmodule

// File: tb/tb_vote_tally_reader.sv
// Bench for vote_tally_reader: frame-level reference model with a per-cycle
// compare process, plus directed scenarios with hand-computed frames.
module tb_vote_tally_reader;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       mode = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tally1 = 8'h00;
    logic [7:0] tally2 = 8'h00;
    logic [7:0] tally3 = 8'h00;
    logic [7:0] tally4 = 8'h00;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       busy;
    logic       frame_done;
    logic [7:0] led;

    vote_tally_reader dut (
        .clock      (clock),
        .reset      (reset),
        .mode       (mode),
        .start      (start),
        .tally1     (tally1),
        .tally2     (tally2),
        .tally3     (tally3),
        .tally4     (tally4),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .busy       (busy),
        .frame_done (frame_done),
        .led        (led)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int first_valid_cyc = 0;
    int acc_cyc = 0;
    logic [7:0] dut_q[$];
    logic       prev_stall = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, req, $time);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: frame contents from max/first-index/count rules,
    // timing from the accept-to-valid latency and the handshake rule.
    logic       m_valid = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_led = 8'h00;
    logic [7:0] m_frame [7];
    int         m_wait = 0;
    int         m_bidx = 0;

    always @(posedge clock) begin : model
        logic [7:0] tv [4];
        logic [7:0] mx;
        logic [7:0] win;
        logic [1:0] wb;
        int         wi;
        int         n;
        if (!reset) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_led   = 8'h00;
            m_wait  = 0;
            m_bidx  = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start && mode) begin
                    tv[0] = tally1; tv[1] = tally2; tv[2] = tally3; tv[3] = tally4;
                    mx = 8'h00;
                    for (int i = 0; i < 4; i++) if (tv[i] > mx) mx = tv[i];
                    wi = 0;
                    n  = 0;
                    for (int i = 3; i >= 0; i--) begin
                        if (tv[i] == mx) begin
                            wi = i;
                            n++;
                        end
                    end
                    wb  = 2'(wi);
                    win = (mx == 8'h00) ? 8'hFF : {(n > 1), 5'b0, wb};
                    m_frame[0] = 8'hA5;
                    for (int i = 0; i < 4; i++) m_frame[i+1] = tv[i];
                    m_frame[5] = win;
                    m_frame[6] = tv[0] ^ tv[1] ^ tv[2] ^ tv[3] ^ win;
                    m_busy = 1'b1;
                    m_wait = 4;
                end
            end else if (!m_valid) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_valid = 1'b1;
                    m_bidx  = 0;
                    m_data  = m_frame[0];
                end
            end else if (out_ready) begin
                if (m_bidx == 6) begin
                    m_valid = 1'b0;
                    m_data  = 8'h00;
                    m_busy  = 1'b0;
                    m_done  = 1'b1;
                    m_led   = m_frame[5];
                end else begin
                    m_bidx++;
                    m_data = m_frame[m_bidx];
                end
            end
        end
    end

    // Per-cycle compare against the model, stall stability and transfer log
    always @(negedge clock) begin
        chk("out_valid", {7'b0, out_valid}, {7'b0, m_valid});
        chk("busy", {7'b0, busy}, {7'b0, m_busy});
        chk("frame_done", {7'b0, frame_done}, {7'b0, m_done});
        chk("led", led, m_led);
        if (m_valid) chk("out_data", out_data, m_data);
        if (out_valid && prev_stall) chk("stall_hold", out_data, prev_data);
        prev_stall = out_valid && !out_ready && reset;
        prev_data  = out_data;
        if (out_valid && out_ready && reset) dut_q.push_back(out_data);
        if (out_valid && !prev_valid) first_valid_cyc = cyc;
        prev_valid = out_valid;
        if (frame_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        acc_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input bit bp);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < limit) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            k++;
        end
        out_ready = 1'b1;
        n_chk++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL wait_done: no frame_done within %0d cycles at %0t", limit, $time);
        end
    endtask

    task automatic check_frame(input string nm, input logic [55:0] req);
        chk({nm, "_len"}, 8'(dut_q.size()), 8'd7);
        for (int k = 0; k < 7; k++) begin
            if (k < dut_q.size()) chk({nm, "_byte"}, dut_q[k], req[55-8*k -: 8]);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_valid"}, {7'b0, out_valid}, 8'h00);
        chk({nm, "_data"}, out_data, 8'h00);
        chk({nm, "_busy"}, {7'b0, busy}, 8'h00);
        chk({nm, "_done"}, {7'b0, frame_done}, 8'h00);
        chk({nm, "_led"}, led, 8'h00);
    endtask

    task automatic set_tallies(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d);
        tally1 = a; tally2 = b; tally3 = c; tally4 = d;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin : stim
        int d;
        int k;

        // Reset held for three cycles
        reset = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();

        // Normal frame
        set_tallies(8'd5, 8'd2, 8'd7, 8'd1);
        mode = 1'b1;
        out_ready = 1'b1;
        dut_q.delete();
        pulse_start();
        wait_done(100, 1'b0);
        check_frame("normal", 56'hA5_05_02_07_01_02_03);
        chk("first_valid_latency", 8'(first_valid_cyc - acc_cyc), 8'd4);
        chk("led_normal", led, 8'h02);

        // Tie between candidates 2 and 3
        set_tallies(8'd4, 8'd9, 8'd9, 8'd0);
        dut_q.delete();
        pulse_start();
        wait_done(100, 1'b0);
        check_frame("tie", 56'hA5_04_09_09_00_81_85);
        chk("led_tie", led, 8'h81);

        // No votes at all
        set_tallies(8'd0, 8'd0, 8'd0, 8'd0);
        dut_q.delete();
        pulse_start();
        wait_done(100, 1'b0);
        check_frame("novote", 56'hA5_00_00_00_00_FF_FF);
        chk("led_novote", led, 8'hFF);

        // Random backpressure
        set_tallies(8'd5, 8'd2, 8'd7, 8'd1);
        dut_q.delete();
        pulse_start();
        wait_done(400, 1'b1);
        check_frame("backpressure", 56'hA5_05_02_07_01_02_03);

        // start ignored in non-result mode
        mode = 1'b0;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            chk("gate_busy", {7'b0, busy}, 8'h00);
            tick();
        end
        mode = 1'b1;

        // Tallies and mode change while the frame is sending
        set_tallies(8'd5, 8'd2, 8'd7, 8'd1);
        dut_q.delete();
        pulse_start();
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        set_tallies(8'h33, 8'h44, 8'h55, 8'h66);
        mode = 1'b0;
        wait_done(100, 1'b0);
        check_frame("isolation", 56'hA5_05_02_07_01_02_03);
        mode = 1'b1;

        // start pulses while busy are dropped
        set_tallies(8'd1, 8'd2, 8'd3, 8'd4);
        d = done_cnt;
        dut_q.delete();
        pulse_start();
        repeat (2) tick();
        pulse_start();
        repeat (3) tick();
        pulse_start();
        wait_done(100, 1'b0);
        repeat (20) tick();
        chk("one_frame_count", 8'(done_cnt - d), 8'd1);
        check_frame("busy_start", 56'hA5_01_02_03_04_03_07);

        // Reset after the third transfer, then a fresh frame
        set_tallies(8'd5, 8'd2, 8'd7, 8'd1);
        d = done_cnt;
        dut_q.delete();
        pulse_start();
        k = 0;
        while (dut_q.size() < 3 && k < 50) begin
            tick();
            k++;
        end
        chk("midreset_xfers", 8'(dut_q.size()), 8'd3);
        reset = 1'b0;
        tick();
        check_reset_outputs("midreset");
        reset = 1'b1;
        repeat (15) tick();
        chk("midreset_no_done", 8'(done_cnt - d), 8'd0);
        set_tallies(8'd4, 8'd9, 8'd9, 8'd0);
        dut_q.delete();
        pulse_start();
        wait_done(100, 1'b0);
        check_frame("after_reset", 56'hA5_04_09_09_00_81_85);
        chk("led_after_reset", led, 8'h81);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
